fir_coef_sequencer: RTL

Run-time coefficient controller for `fir_filter`, placed between the input stream source and the filter's input stream port. It sequences a coefficient change without mixing old and new coefficients:
- buffers host writes in a shadow bank;
- on commit, stalls the input stream and drains samples in flight;
- optionally flushes the delay line with zeros;
- swaps banks atomically and resumes streaming.

---
 rtl/fir_coef_pkg.sv | 22 ++
 rtl/fir_coef_bank.sv | 55 +++++
 rtl/fir_coef_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fir_coef_pkg.sv
// Shared types and constants for the fir_filter coefficient sequencer.
// Optional delay-line flush is enabled with the FIR_COEF_FLUSH_EN macro.
package fir_coef_pkg;

    localparam int FIR_NTAPS        = 8;
    localparam int FIR_WW_INPUT     = 16;
    localparam int FIR_WW_COEF      = 16;
    localparam int FIR_MAX_INFLIGHT = 15;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_SWAP  = 2'd3
    } state_e;

    // Index width for a tap array; a single-tap filter still needs one bit.
    function automatic int fir_coef_aw(input int ntaps);
        return (ntaps > 1) ? $clog2(ntaps) : 1;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient register banks with a write port and an
// atomic shadow-to-active swap strobe.
module fir_coef_bank
    import fir_coef_pkg::*;
#(
    parameter int NTAPS   = FIR_NTAPS,
    parameter int WW_COEF = FIR_WW_COEF,
    localparam int AW     = fir_coef_aw(NTAPS)
)(
    input  logic                        clk,
    input  logic                        i_srst,
    input  logic                        i_we,
    input  logic [AW-1:0]               i_addr,
    input  logic signed [WW_COEF-1:0]   i_data,
    input  logic                        i_swap,
    output logic [NTAPS*WW_COEF-1:0]    o_coef_flat
);

    logic signed [WW_COEF-1:0] shadow_q [NTAPS];
    logic signed [WW_COEF-1:0] shadow_d [NTAPS];
    logic signed [WW_COEF-1:0] active_q [NTAPS];
    logic signed [WW_COEF-1:0] active_d [NTAPS];

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        // Out-of-range addresses are dropped rather than aliased.
        if (i_we && (int'(i_addr) < NTAPS)) begin
            shadow_d[i_addr] = i_data;
        end
        if (i_swap) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        o_coef_flat = '0;
        for (int k = 0; k < NTAPS; k++) begin
            o_coef_flat[k*WW_COEF +: WW_COEF] = active_q[k];
        end
    end

endmodule

// File: rtl/fir_coef_sequencer.sv
// Run-time coefficient controller: stalls the stream, drains in-flight samples,
// optionally flushes zeros (FIR_COEF_FLUSH_EN), then swaps coefficient banks.
module fir_coef_sequencer
    import fir_coef_pkg::*;
#(
    parameter int NTAPS        = FIR_NTAPS,
    parameter int WW_INPUT     = FIR_WW_INPUT,
    parameter int WW_COEF      = FIR_WW_COEF,
    parameter int MAX_INFLIGHT = FIR_MAX_INFLIGHT,
    localparam int AW          = fir_coef_aw(NTAPS)
)(
    input  logic                        clk,
    input  logic                        i_srst,
    input  logic                        i_en,
    input  logic [AW-1:0]               i_cfg_addr,
    input  logic [WW_COEF-1:0]          i_cfg_data,
    input  logic                        i_cfg_we,
    input  logic                        i_cfg_commit,
    output logic                        o_cfg_busy,
    input  logic [WW_INPUT-1:0]         i_is_data,
    input  logic                        i_is_dv,
    output logic                        o_is_rfd,
    output logic [WW_INPUT-1:0]         o_fir_data,
    output logic                        o_fir_dv,
    input  logic                        i_fir_rfd,
    input  logic                        i_fir_os_dv,
    input  logic                        i_fir_os_rfd,
    output logic [NTAPS*WW_COEF-1:0]    o_coef_flat
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] INFL_MAX = CW'(MAX_INFLIGHT);

    state_e        state_q, state_d;
    logic [CW-1:0] infl_q, infl_d;
    logic          fir_accept;
    logic          fir_out_xfer;
    logic          bank_we;
    logic          bank_swap;

`ifdef FIR_COEF_FLUSH_EN
    localparam int FW = fir_coef_aw(NTAPS);
    logic [FW-1:0] flush_q, flush_d;
`endif

    // Stream muxing; everything is gated during reset and clock-enable low.
    always_comb begin
        o_fir_data = '0;
        o_fir_dv   = 1'b0;
        o_is_rfd   = 1'b0;
        o_cfg_busy = (state_q != ST_RUN) && !i_srst;
        if (!i_srst && i_en) begin
            case (state_q)
                ST_RUN: begin
                    o_fir_data = i_is_data;
                    o_fir_dv   = i_is_dv;
                    o_is_rfd   = i_fir_rfd;
                end
                ST_FLUSH: begin
                    o_fir_dv = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fir_accept   = o_fir_dv & i_fir_rfd;
    assign fir_out_xfer = i_fir_os_dv & i_fir_os_rfd & i_en;

    always_comb begin
        infl_d = infl_q;
        if (fir_accept && !fir_out_xfer && (infl_q != INFL_MAX)) begin
            infl_d = infl_q + 1'b1;
        end else if (!fir_accept && fir_out_xfer && (infl_q != '0)) begin
            infl_d = infl_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bank_we   = 1'b0;
        bank_swap = 1'b0;
`ifdef FIR_COEF_FLUSH_EN
        flush_d   = flush_q;
`endif
        if (i_en) begin
            case (state_q)
                ST_RUN: begin
                    // A write in the commit cycle lands before the swap.
                    bank_we = i_cfg_we;
                    if (i_cfg_commit) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (infl_q == '0) begin
`ifdef FIR_COEF_FLUSH_EN
                        state_d = ST_FLUSH;
                        flush_d = '0;
`else
                        state_d = ST_SWAP;
`endif
                    end
                end
`ifdef FIR_COEF_FLUSH_EN
                ST_FLUSH: begin
                    if (fir_accept) begin
                        if (flush_q == FW'(NTAPS - 1)) begin
                            flush_d = '0;
                            state_d = ST_SWAP;
                        end else begin
                            flush_d = flush_q + 1'b1;
                        end
                    end
                end
`endif
                ST_SWAP: begin
                    bank_swap = 1'b1;
                    state_d   = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            state_q <= ST_RUN;
            infl_q  <= '0;
`ifdef FIR_COEF_FLUSH_EN
            flush_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
`ifdef FIR_COEF_FLUSH_EN
            flush_q <= flush_d;
`endif
        end
    end

    fir_coef_bank #(
        .NTAPS   (NTAPS),
        .WW_COEF (WW_COEF)
    ) u_bank (
        .clk         (clk),
        .i_srst      (i_srst),
        .i_we        (bank_we),
        .i_addr      (i_cfg_addr),
        .i_data      (i_cfg_data),
        .i_swap      (bank_swap),
        .o_coef_flat (o_coef_flat)
    );

endmodule
